// File: rtl/lfsr_ks_sched_if.sv
// Bundle between lfsr_ks_sched and its environment: requester side, keystream
// stream and the LFSR control/readback lines. master = scheduler side.
interface lfsr_ks_sched_if #(
  parameter int unsigned LEN_W = 8
);
  logic [1:0]       req;
  logic [31:0]      seed0;
  logic [31:0]      seed1;
  logic [LEN_W-1:0] len0;
  logic [LEN_W-1:0] len1;
  logic [1:0]       gnt;
  logic [1:0]       done;
  logic [7:0]       ks_byte;
  logic             ks_valid;
  logic             ks_ready;
  logic             ks_owner;
  logic [31:0]      lfsr_ld_val;
  logic             lfsr_ld;
  logic             lfsr_step;
  logic [31:0]      lfsr_val;
  logic             busy;

  modport master (
    input  req, seed0, seed1, len0, len1, ks_ready, lfsr_val,
    output gnt, done, ks_byte, ks_valid, ks_owner,
           lfsr_ld_val, lfsr_ld, lfsr_step, busy
  );

  modport slave (
    output req, seed0, seed1, len0, len1, ks_ready, lfsr_val,
    input  gnt, done, ks_byte, ks_valid, ks_owner,
           lfsr_ld_val, lfsr_ld, lfsr_step, busy
  );
endinterface

// File: rtl/lfsr_ks_sched.sv
// Round-robin keystream scheduler sharing one external 32-bit LFSR between two
// requesters. Optional macro LFSR_ZERO_GUARD_EN maps an all-zero seed to 1.
module lfsr_ks_sched #(
  parameter int unsigned STEPS_PER_BYTE = 8,
  parameter int unsigned LEN_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  lfsr_ks_sched_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STEP,
    S_EMIT,
    S_FIN
  } state_t;

  localparam logic [7:0] STEP_LAST = 8'(STEPS_PER_BYTE - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_last;
  logic             r_owner;
  logic [1:0]       r_gnt;
  logic [31:0]      r_seed;
  logic [LEN_W-1:0] r_rem;
  logic [7:0]       r_step_cnt;

  logic             w_req_any;
  logic             w_win;
  logic             w_xfer;
  logic             w_step_last;
  logic [31:0]      w_seed_ld;
  logic             w_unused_lfsr_hi;

  assign w_req_any        = |bus.req;
  // On a tie the requester that was not served last wins.
  assign w_win            = (bus.req == 2'b11) ? ~r_last : bus.req[1];
  assign w_xfer           = (r_state == S_EMIT) && bus.ks_ready;
  assign w_step_last      = (r_step_cnt == STEP_LAST);
  assign w_unused_lfsr_hi = ^bus.lfsr_val[31:8];

`ifdef LFSR_ZERO_GUARD_EN
  assign w_seed_ld = (r_seed == '0) ? 32'h0000_0001 : r_seed;
`else
  assign w_seed_ld = r_seed;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    bus.gnt          = r_gnt;
    bus.done         = '0;
    bus.ks_byte      = '0;
    bus.ks_valid     = 1'b0;
    bus.ks_owner     = 1'b0;
    bus.lfsr_ld_val  = '0;
    bus.lfsr_ld      = 1'b0;
    bus.lfsr_step    = 1'b0;
    bus.busy         = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (w_req_any) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        bus.lfsr_ld     = 1'b1;
        bus.lfsr_ld_val = w_seed_ld;
        w_state_nxt     = (r_rem == '0) ? S_FIN : S_STEP;
      end
      S_STEP: begin
        bus.lfsr_step = 1'b1;
        if (w_step_last) w_state_nxt = S_EMIT;
      end
      S_EMIT: begin
        bus.ks_valid = 1'b1;
        bus.ks_byte  = bus.lfsr_val[7:0];
        bus.ks_owner = r_owner;
        if (w_xfer) w_state_nxt = (r_rem == LEN_W'(1)) ? S_FIN : S_STEP;
      end
      S_FIN: begin
        bus.done    = r_owner ? 2'b10 : 2'b01;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last     <= 1'b1;
      r_owner    <= 1'b0;
      r_gnt      <= '0;
      r_seed     <= '0;
      r_rem      <= '0;
      r_step_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req_any) begin
            r_owner <= w_win;
            r_last  <= w_win;
            r_gnt   <= w_win ? 2'b10 : 2'b01;
            r_seed  <= w_win ? bus.seed1 : bus.seed0;
            r_rem   <= w_win ? bus.len1 : bus.len0;
          end
        end
        S_LOAD: r_step_cnt <= '0;
        S_STEP: r_step_cnt <= r_step_cnt + 8'd1;
        S_EMIT: begin
          if (w_xfer) begin
            r_rem      <= r_rem - LEN_W'(1);
            r_step_cnt <= '0;
          end
        end
        S_FIN:   r_gnt <= '0;
        default: ;
      endcase
    end
  end

endmodule
